uart_rx_frame: RTL

Byte-level frame decoder that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle data-valid strobe and byte, and locates frames of the form SOF, CMD, LEN, payload, CHK. It checks length and checksum, buffers the payload for random-access readout, and reports completion or error with one-cycle pulses. It supervises inter-byte gaps with a timeout so a truncated frame cannot wedge the decoder.

---
 rtl/uart_rx_frame_if.sv | 23 ++
 rtl/uart_rx_frame.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Byte-strobe input, payload read port and frame status outputs of the frame decoder.
interface uart_rx_frame_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic [3:0] i_Rd_Addr;
  logic       o_Frame_Valid;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;
  logic [7:0] o_Cmd;
  logic [4:0] o_Len;
  logic [7:0] o_Rd_Data;
  logic       o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Rd_Addr,
    input  o_Frame_Valid, o_Frame_Err, o_Err_Code, o_Cmd, o_Len, o_Rd_Data, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Rd_Addr,
    output o_Frame_Valid, o_Frame_Err, o_Err_Code, o_Cmd, o_Len, o_Rd_Data, o_Busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Decodes SOF/CMD/LEN/payload/CHK frames; status pulses one cycle after the final strobe.
// No backpressure: a byte strobe every cycle is accepted, inter-byte gaps are time-limited.
module uart_rx_frame #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 118100
) (
  input  logic            osc_clk,
  input  logic            i_rst,
  uart_rx_frame_if.slave  bus
);

  localparam logic [7:0]  SOF_BYTE = 8'h55;
  localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);
  localparam logic [16:0] CNT_LAST = 17'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [16:0] r_cnt;
  logic [7:0]  r_cmd_sh;
  logic [4:0]  r_len_sh;
  logic [7:0]  r_sum;
  logic [3:0]  r_idx;
  logic [7:0]  r_cmd;
  logic [4:0]  r_len;
  logic        r_valid;
  logic        r_err;
  logic [1:0]  r_code;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [16];

  logic        w_valid;
  logic        w_err;
  logic [1:0]  w_code;
  logic        w_wr_en;
  logic        w_expire;
  logic        w_last;
  logic [7:0]  w_sum_add;

  assign w_sum_add = r_sum + bus.i_Rx_Byte;
  assign w_last    = ({1'b0, r_idx} == (r_len_sh - 5'd1));
  // A strobe on the expiry cycle takes priority over the timeout.
  assign w_expire  = (r_state != S_IDLE) && !bus.i_Rx_DV && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_err       = 1'b0;
    w_code      = r_code;
    w_wr_en     = 1'b0;
    if (w_expire) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
      w_code      = 2'b11;
    end else if (bus.i_Rx_DV) begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_Rx_Byte == SOF_BYTE) w_state_nxt = S_CMD;
        end
        S_CMD: w_state_nxt = S_LEN;
        S_LEN: begin
          if (bus.i_Rx_Byte > LEN_MAX) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
            w_code      = 2'b01;
          end else if (bus.i_Rx_Byte == 8'h00) begin
            w_state_nxt = S_CHK;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_wr_en = 1'b1;
          if (w_last) w_state_nxt = S_CHK;
        end
        S_CHK: begin
          w_state_nxt = S_IDLE;
          if (w_sum_add == 8'h00) begin
            w_valid = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = 2'b10;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_code  <= w_code;
      if (bus.i_Rx_DV || (r_state == S_IDLE) || w_expire) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + 17'd1;
    end
  end

  always_ff @(posedge osc_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd_sh <= '0;
      r_len_sh <= '0;
      r_sum    <= '0;
      r_idx    <= '0;
      r_cmd    <= '0;
      r_len    <= '0;
    end else begin
      if (bus.i_Rx_DV && !w_expire) begin
        case (r_state)
          S_CMD: begin
            r_cmd_sh <= bus.i_Rx_Byte;
            r_sum    <= bus.i_Rx_Byte;
          end
          S_LEN: begin
            r_len_sh <= bus.i_Rx_Byte[4:0];
            r_sum    <= w_sum_add;
            r_idx    <= '0;
          end
          S_PAYLOAD: begin
            r_sum <= w_sum_add;
            r_idx <= r_idx + 4'd1;
          end
          default: ;
        endcase
      end
      if (w_valid) begin
        r_cmd <= r_cmd_sh;
        r_len <= r_len_sh;
      end
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge osc_clk) begin
    if (w_wr_en) r_mem[r_idx] <= bus.i_Rx_Byte;
  end

  always_ff @(posedge osc_clk or posedge i_rst) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[bus.i_Rd_Addr];
  end

  assign bus.o_Frame_Valid = r_valid;
  assign bus.o_Frame_Err   = r_err;
  assign bus.o_Err_Code    = r_code;
  assign bus.o_Cmd         = r_cmd;
  assign bus.o_Len         = r_len;
  assign bus.o_Rd_Data     = r_rd_data;
  assign bus.o_Busy        = (r_state != S_IDLE);

endmodule
